// File: rtl/random_pulse_gen.sv
// random_pulse_gen
//   Random pulse source for stimulus and self-test. A 16-bit Galois LFSR
//   (taps 16'hB400, shifting right) picks, for each pulse, a gap before it,
//   a pulse width and an active channel. With a fixed seed the sequence is
//   reproducible.
//
//   Optional feature: define RANDOM_PULSE_MULTI_EN to drive a multi-channel
//   mask during PULSE. The mask is lfsr[15:0] replicated across WIDTH bits,
//   ORed with the drawn channel bit, so it is never zero. Without the macro,
//   dout is strictly one-hot or zero.
//
// Ports
//   clk        in   1      clock
//   rst        in   1      async reset, active-high
//   en         in   1      run enable; the LFSR advances only while en=1
//   load_seed  in   1      load seed_in into the LFSR (honoured in IDLE/DONE only)
//   seed_in    in   16     seed value; 0 is replaced by SEED
//   dout       out  WIDTH  registered pulse output
//   busy       out  1      1 in GAP or PULSE
//   done       out  1      1 in DONE
//   pulse_cnt  out  16     pulses completed this run, saturating
module random_pulse_gen #(
  parameter int          WIDTH      = 10,
  parameter int          UNIT       = 20,
  parameter int          GAP_MAX    = 5,
  parameter int          PW_MIN     = 1,
  parameter int          PW_MAX     = 3,
  parameter int          NUM_PULSES = 100,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_seed,
  input  logic [15:0]      seed_in,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic [15:0]      pulse_cnt
);

  localparam logic [15:0] TAPS = 16'hB400;
  localparam int GMAX = GAP_MAX * UNIT;
  localparam int PMAX = PW_MAX * UNIT;
  localparam int CMAX = (GMAX > PMAX) ? GMAX : PMAX;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int CHW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, GAP, PULSE, DONE} state_t;

  state_t           state;
  logic [15:0]      lfsr, lfsr_nxt;
  logic [CW-1:0]    gap_ctr, pw_ctr;
  logic [CW-1:0]    gap_d, pw_d;
  logic [CHW-1:0]   chan_d;
  logic [WIDTH-1:0] pat, pat_d;     // value driven onto dout for this pulse
  logic [16:0]      cnt_inc;
  logic             last_pulse;
  logic             seed_ok;

  // Draws come from the current LFSR value, taken on the edge that enters GAP.
  // The width counter is loaded at GAP entry (p*UNIT-1) and left untouched
  // until PULSE starts counting it down.
  always_comb begin
    lfsr_nxt = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    chan_d   = CHW'(int'(lfsr[7:0]) % WIDTH);
    gap_d    = CW'((int'(lfsr[11:4]) % (GAP_MAX + 1)) * UNIT);
    pw_d     = CW'((PW_MIN + int'(lfsr[15:8]) % (PW_MAX - PW_MIN + 1)) * UNIT - 1);
    pat_d    = '0;
`ifdef RANDOM_PULSE_MULTI_EN
    for (int i = 0; i < WIDTH; i++) pat_d[i] = lfsr[i % 16];
    pat_d = pat_d | (WIDTH'(1) << chan_d);
`else
    pat_d = WIDTH'(1) << chan_d;
`endif
    cnt_inc    = {1'b0, pulse_cnt} + 17'd1;
    last_pulse = (NUM_PULSES != 0) && (cnt_inc == 17'(NUM_PULSES));
    seed_ok    = load_seed && (state == IDLE || state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr      <= SEED;
      state     <= IDLE;
      dout      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
      gap_ctr   <= '0;
      pw_ctr    <= '0;
      pat       <= '0;
    end else begin
      // A zero seed would lock the LFSR, so it falls back to SEED.
      if (seed_ok)  lfsr <= (seed_in == 16'd0) ? SEED : seed_in;
      else if (en)  lfsr <= lfsr_nxt;

      case (state)
        IDLE: begin
          dout <= '0;
          // A seed load in the same cycle as en takes priority; stay put.
          if (en && !load_seed) begin
            state   <= GAP;
            busy    <= 1'b1;
            gap_ctr <= gap_d;
            pw_ctr  <= pw_d;
            pat     <= pat_d;
          end
        end
        GAP: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (gap_ctr == '0) begin
            state <= PULSE;
            dout  <= pat;
          end else begin
            gap_ctr <= gap_ctr - 1'b1;
          end
        end
        PULSE: begin
          // en is ignored here so a pulse always runs its full width.
          if (pw_ctr != '0) begin
            pw_ctr <= pw_ctr - 1'b1;
          end else begin
            dout <= '0;
            if (pulse_cnt != 16'hFFFF) pulse_cnt <= pulse_cnt + 16'd1;
            if (last_pulse) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (en) begin
              state   <= GAP;
              gap_ctr <= gap_d;
              pw_ctr  <= pw_d;
              pat     <= pat_d;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        DONE: begin
          dout <= '0;
          if (!en) begin
            state     <= IDLE;
            done      <= 1'b0;
            pulse_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          dout  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_pulse_gen.sv
// Directed bench for random_pulse_gen. Four instances cover the default
// configuration, a short counted run, a fixed 60-cycle pulse width, and a
// one-cycle-per-phase configuration.
module tb_random_pulse_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [4];
  logic        en  [4];
  logic        ld  [4];
  logic [15:0] sd  [4];
  logic [9:0]  dout[4];
  logic        busy[4];
  logic        done[4];
  logic [15:0] pcnt[4];

  int n_run  = 0;
  int n_fail = 0;

  random_pulse_gen u0 (
    .clk(clk), .rst(rst[0]), .en(en[0]), .load_seed(ld[0]), .seed_in(sd[0]),
    .dout(dout[0]), .busy(busy[0]), .done(done[0]), .pulse_cnt(pcnt[0]));

  random_pulse_gen #(.UNIT(2), .NUM_PULSES(3)) u1 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .load_seed(ld[1]), .seed_in(sd[1]),
    .dout(dout[1]), .busy(busy[1]), .done(done[1]), .pulse_cnt(pcnt[1]));

  random_pulse_gen #(.PW_MIN(3), .PW_MAX(3)) u2 (
    .clk(clk), .rst(rst[2]), .en(en[2]), .load_seed(ld[2]), .seed_in(sd[2]),
    .dout(dout[2]), .busy(busy[2]), .done(done[2]), .pulse_cnt(pcnt[2]));

  random_pulse_gen #(.UNIT(1), .GAP_MAX(0), .PW_MIN(1), .PW_MAX(1), .NUM_PULSES(0)) u3 (
    .clk(clk), .rst(rst[3]), .en(en[3]), .load_seed(ld[3]), .seed_in(sd[3]),
    .dout(dout[3]), .busy(busy[3]), .done(done[3]), .pulse_cnt(pcnt[3]));

  // Reference Galois LFSR, advanced n steps.
  function automatic logic [15:0] adv(input logic [15:0] s, input int n);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = t[0] ? ((t >> 1) ^ 16'hB400) : (t >> 1);
    return t;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; ld[i] = 1'b0; sd[i] = 16'd0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_run++; if (dout[i] !== 10'd0) begin n_fail++; $display("FAIL reset_dout[%0d] got %h exp 0", i, dout[i]); end
      n_run++; if (busy[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d] got %b exp 0", i, busy[i]); end
      n_run++; if (done[i] !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d] got %b exp 0", i, done[i]); end
      n_run++; if (pcnt[i] !== 16'd0) begin n_fail++; $display("FAIL reset_pcnt[%0d] got %0d exp 0", i, pcnt[i]); end
    end
    n_run++; if (u0.lfsr !== 16'hACE1) begin n_fail++; $display("FAIL reset_lfsr got %h exp ace1", u0.lfsr); end
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
  endtask

  // First 8 (chan, gap, width) tuples against the reference model.
  task automatic test_sequence();
    logic [15:0] s;
    logic [9:0]  pat, expv;
    int ch, g, p, nz, nh;
    s = 16'hACE1;
    @(negedge clk); en[0] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      ch = int'(s[7:0]) % 10;
      g  = int'(s[11:4]) % 6;
      p  = 1 + int'(s[15:8]) % 3;
      nz = 0;
      while (dout[0] == 10'd0 && nz < 200) begin nz++; @(negedge clk); end
      pat = dout[0]; nh = 0;
      while (pat != 10'd0 && dout[0] == pat && nh < 200) begin nh++; @(negedge clk); end
      n_run++; if (nz != g * 20 + 1) begin n_fail++; $display("FAIL seq_gap[%0d] got %0d exp %0d", k, nz, g * 20 + 1); end
      n_run++; if (nh != p * 20) begin n_fail++; $display("FAIL seq_width[%0d] got %0d exp %0d", k, nh, p * 20); end
      expv = 10'd1 << ch;
`ifdef RANDOM_PULSE_MULTI_EN
      n_run++; if ((pat & expv) !== expv) begin n_fail++; $display("FAIL seq_chan[%0d] got %h need bit %0d", k, pat, ch); end
`else
      n_run++; if (pat !== expv) begin n_fail++; $display("FAIL seq_chan[%0d] got %h exp %h", k, pat, expv); end
`endif
      s = adv(s, g * 20 + 1 + p * 20);
    end
  endtask

  task automatic test_midpulse_reset();
    int n;
    n = 0;
    while (dout[0] == 10'd0 && n < 200) begin n++; @(negedge clk); end
    n_run++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b exp 1", busy[0]); end
    n_run++; if (pcnt[0] !== 16'd8) begin n_fail++; $display("FAIL mid_pcnt got %0d exp 8", pcnt[0]); end
    #1 rst[0] = 1'b1;
    #1;
    n_run++; if (dout[0] !== 10'd0) begin n_fail++; $display("FAIL arst_dout got %h exp 0", dout[0]); end
    n_run++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b exp 0", busy[0]); end
    n_run++; if (done[0] !== 1'b0) begin n_fail++; $display("FAIL arst_done got %b exp 0", done[0]); end
    n_run++; if (pcnt[0] !== 16'd0) begin n_fail++; $display("FAIL arst_pcnt got %0d exp 0", pcnt[0]); end
    en[0] = 1'b0;
    @(negedge clk); rst[0] = 1'b0;
    @(negedge clk);
    n_run++; if (u0.lfsr !== 16'hACE1) begin n_fail++; $display("FAIL arst_lfsr got %h exp ace1", u0.lfsr); end
    n_run++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL arst_idle got %b exp 0", busy[0]); end
  endtask

  task automatic test_num_pulses();
    logic [9:0] pat;
    int nz, nh, bad;
    en[1] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      nz = 0;
      while (dout[1] == 10'd0 && nz < 100) begin nz++; @(negedge clk); end
      pat = dout[1]; nh = 0;
      while (pat != 10'd0 && dout[1] == pat && nh < 100) begin nh++; @(negedge clk); end
      n_run++; if (!(nh == 2 || nh == 4 || nh == 6)) begin n_fail++; $display("FAIL np_width[%0d] got %0d exp 2/4/6", k, nh); end
`ifdef RANDOM_PULSE_MULTI_EN
      n_run++; if (pat == 10'd0) begin n_fail++; $display("FAIL np_nonzero[%0d] got %h", k, pat); end
`else
      n_run++; if (!$onehot(pat)) begin n_fail++; $display("FAIL np_onehot[%0d] got %h", k, pat); end
`endif
      n_run++; if (pcnt[1] !== 16'(k + 1)) begin n_fail++; $display("FAIL np_pcnt[%0d] got %0d exp %0d", k, pcnt[1], k + 1); end
    end
    n_run++; if (done[1] !== 1'b1) begin n_fail++; $display("FAIL np_done got %b exp 1", done[1]); end
    n_run++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL np_busy got %b exp 0", busy[1]); end
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (dout[1] != 10'd0 || done[1] != 1'b1 || pcnt[1] != 16'd3) bad++;
    end
    n_run++; if (bad != 0) begin n_fail++; $display("FAIL np_hold got %0d bad cycles exp 0", bad); end
    en[1] = 1'b0;
    @(negedge clk);
    n_run++; if (done[1] !== 1'b0) begin n_fail++; $display("FAIL np_idle_done got %b exp 0", done[1]); end
    n_run++; if (pcnt[1] !== 16'd0) begin n_fail++; $display("FAIL np_clear got %0d exp 0", pcnt[1]); end
  endtask

  task automatic test_en_drop();
    logic [15:0] l0;
    int n, nh;
    en[2] = 1'b1;
    n = 0;
    @(negedge clk);
    while (dout[2] == 10'd0 && n < 200) begin n++; @(negedge clk); end
    en[2] = 1'b0;
    @(negedge clk);
    l0 = u2.lfsr;
    nh = 1;
    while (dout[2] != 10'd0 && nh < 100) begin nh++; @(negedge clk); end
    n_run++; if (nh != 60) begin n_fail++; $display("FAIL drop_width got %0d exp 60", nh); end
    n_run++; if (busy[2] !== 1'b0) begin n_fail++; $display("FAIL drop_busy got %b exp 0", busy[2]); end
    n_run++; if (pcnt[2] !== 16'd1) begin n_fail++; $display("FAIL drop_pcnt got %0d exp 1", pcnt[2]); end
    repeat (10) @(negedge clk);
    n_run++; if (u2.lfsr !== l0) begin n_fail++; $display("FAIL drop_lfsr got %h exp %h", u2.lfsr, l0); end
    n_run++; if (dout[2] !== 10'd0) begin n_fail++; $display("FAIL drop_dout got %h exp 0", dout[2]); end
  endtask

  task automatic test_alternate_and_seed();
    logic [15:0] s, l;
    logic [9:0]  expv;
    s = 16'hACE1;
    en[3] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        n_run++; if (dout[3] !== 10'd0) begin n_fail++; $display("FAIL alt_zero[%0d] got %h exp 0", i, dout[3]); end
      end else begin
        expv = 10'd1 << (int'(s[7:0]) % 10);
`ifdef RANDOM_PULSE_MULTI_EN
        n_run++; if ((dout[3] & expv) !== expv) begin n_fail++; $display("FAIL alt_pulse[%0d] got %h need %h", i, dout[3], expv); end
`else
        n_run++; if (dout[3] !== expv) begin n_fail++; $display("FAIL alt_pulse[%0d] got %h exp %h", i, dout[3], expv); end
`endif
        s = adv(s, 2);
      end
      @(negedge clk);
    end
    en[3] = 1'b0;
    @(negedge clk);
    n_run++; if (busy[3] !== 1'b0) begin n_fail++; $display("FAIL alt_stop got %b exp 0", busy[3]); end
    ld[3] = 1'b1; sd[3] = 16'h0000;
    @(negedge clk);
    n_run++; if (u3.lfsr !== 16'hACE1) begin n_fail++; $display("FAIL seed_zero got %h exp ace1", u3.lfsr); end
    sd[3] = 16'h1234;
    @(negedge clk);
    n_run++; if (u3.lfsr !== 16'h1234) begin n_fail++; $display("FAIL seed_load got %h exp 1234", u3.lfsr); end
    sd[3] = 16'h0000; en[3] = 1'b1;
    @(negedge clk);
    n_run++; if (busy[3] !== 1'b0) begin n_fail++; $display("FAIL seed_wins_busy got %b exp 0", busy[3]); end
    n_run++; if (u3.lfsr !== 16'hACE1) begin n_fail++; $display("FAIL seed_wins_lfsr got %h exp ace1", u3.lfsr); end
    ld[3] = 1'b0;
    @(negedge clk);
    n_run++; if (busy[3] !== 1'b1) begin n_fail++; $display("FAIL seed_gap_busy got %b exp 1", busy[3]); end
    l = u3.lfsr;
    ld[3] = 1'b1; sd[3] = 16'h5555;
    @(negedge clk);
    n_run++; if (u3.lfsr !== adv(l, 1)) begin n_fail++; $display("FAIL seed_ignored got %h exp %h", u3.lfsr, adv(l, 1)); end
    ld[3] = 1'b0; en[3] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_midpulse_reset();
    test_num_pulses();
    test_en_drop();
    test_alternate_and_seed();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
